cgra_im_loader: RTL and testbench
=================================

Name: cgra_im_loader

Overview:
- Upstream configuration stage for the CGRA memory block.
- Accepts a 32-bit valid/ready word stream from the host or boot controller and parses it into per-memory load commands.
- Drives the shared instruction-memory write port: one-hot write enable, write address, ID-width data and IMM-width data, one instruction per write.
- Immediate instructions wider than 32 bits are assembled from two stream words.

Parameters:
- D_WIDTH, 32, stream word width (fixed at 32).
- I_WIDTH, 12, decoder instruction width (must be ≤32).
- I_IMM_WIDTH, 33, immediate-unit instruction width (33..64).
- IM_MEM_ADDR_WIDTH, 8, instruction memory address width.
- NUM_ID, 10, number of decoder instruction memories (targets 0..NUM_ID-1).
- NUM_IMM, 4, number of immediate memories (targets NUM_ID..NUM_ID+NUM_IMM-1).

Ports:
- iClk, in, 1, clock.
- iReset, in, 1, synchronous active-high reset.
- iHold, in, 1, stall input; while high the stream is not accepted.
- iLoad_Data, in, D_WIDTH, stream word.
- iLoad_Valid, in, 1, stream word valid.
- oLoad_Ready, out, 1, stream ready.
- oIM_WriteEnable, out, NUM_ID+NUM_IMM, one-hot write strobe.
- oIM_WriteAddress, out, IM_MEM_ADDR_WIDTH, write address.
- oIM_WriteData, out, I_WIDTH, decoder instruction.
- oIM_WriteData_IMM, out, I_IMM_WIDTH, immediate instruction.
- oBusy, out, 1, high while a command is in progress.
- oDone, out, 1, one-cycle pulse when a command completes.
- oError, out, 1, sticky flag for an invalid target.

Behaviour:
- Handshake
  - Word transfer when iLoad_Valid && oLoad_Ready.
  - oLoad_Ready = ~iHold (combinational); it is deasserted during the reset cycle.
- Header word, accepted in HEADER state:
  - [7:0] target index T.
  - [15:8] start address A (low IM_MEM_ADDR_WIDTH bits used).
  - [31:16] instruction count N.
- States: HEADER, DATA_LO, DATA_HI.
  - HEADER: on header with N=0 → stay in HEADER, pulse oDone next cycle, no write. On N>0 → DATA_LO.
  - DATA_LO, T<NUM_ID:
    - Word accepted → issue write with data = word[I_WIDTH-1:0].
    - Decrement remaining count; → HEADER when it reaches 0, else stay.
  - DATA_LO, T≥NUM_ID (immediate or invalid): latch word as bits [31:0] → DATA_HI.
  - DATA_HI: word[I_IMM_WIDTH-33:0] supplies bits [I_IMM_WIDTH-1:32]; issue the write, decrement count, → DATA_LO or HEADER.
- Write timing
  - All write outputs are registered.
  - oIM_WriteEnable[T] is high for exactly one cycle, in the cycle after the completing word is accepted.
  - Address and data are valid in that same cycle.
  - oIM_WriteEnable is all-zero in every other cycle.
- Address
  - Starts at A and increments by 1 per instruction.
  - Wraps modulo 2^IM_MEM_ADDR_WIDTH (0xFF → 0x00 at default width) with no error.
- Data bus behaviour
  - Decoder target: oIM_WriteData is written, oIM_WriteData_IMM holds its previous value.
  - Immediate target: the reverse.
- Invalid target (T ≥ NUM_ID+NUM_IMM)
  - Parsed as an immediate-format command: 2N words consumed, no write-enable bit ever set.
  - oError set the cycle after the header; it clears only on reset.
- oDone
  - Pulses in the same cycle as the final write enable.
  - For N=0 or an invalid target, it pulses the cycle after the last consumed word.
- oBusy = (state != HEADER) or a write is pending in the output register.
- Gaps in iLoad_Valid or iHold assertions mid-command only pause the state machine; no state is lost.
- Reset
  - State → HEADER; count and address → 0.
  - oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM, oBusy, oDone, oError → 0.
  - Reset mid-command abandons the command: a write registered in that cycle is suppressed and no partial immediate is written.
- Widths
  - Count is 16 bits unsigned.
  - Excess header bits beyond IM_MEM_ADDR_WIDTH are ignored.

Test Plan:
- Decoder load: header 0x0003_10_04, then data 0xABC, 0x123, 0xFFF → WE bit4 on three consecutive write cycles at addresses 0x10/0x11/0x12 with data 0xABC/0x123/0xFFF; oDone pulses with the third write; oError=0.
- Immediate load: header 0x0001_05_0B (T=11=IMM1), then 0xDEADBEEF, 0x00000001 → single write, WE bit11, address 0x05, IMM data 0x1_DEADBEEF; no write after the first data word.
- Wrap plus count zero: header 0x0002_FF_00, data 1, 2 → addresses 0xFF then 0x00. Next, header 0x0000_00_02 → no write, oDone pulses one cycle after acceptance.
- Invalid target: header 0x0002_00_20, then four words → zero write enables; oError=1 from the cycle after the header and held through a following valid load to target 0.
- Back-pressure: random iLoad_Valid gaps and iHold toggling during a 5-instruction immediate load → identical write sequence to the gap-free run; no word is accepted while iHold=1.
- Reset mid-op: assert iReset after the DATA_LO word of an immediate command → no write ever issued. The next header then loads correctly from the given start address.

Source files
------------

// File: rtl/cgra_im_loader.sv
// rtl/cgra_im_loader.sv - parses a 32-bit load stream into instruction-memory write commands
module cgra_im_loader #(
  parameter int D_WIDTH           = 32,
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int NUM_ID            = 10,
  parameter int NUM_IMM           = 4
) (
  input  logic                          iClk,
  input  logic                          iReset,
  input  logic                          iHold,
  input  logic [D_WIDTH-1:0]            iLoad_Data,
  input  logic                          iLoad_Valid,
  output logic                          oLoad_Ready,
  output logic [NUM_ID+NUM_IMM-1:0]     oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0]  oIM_WriteAddress,
  output logic [I_WIDTH-1:0]            oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]        oIM_WriteData_IMM,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oError
);

  localparam int NUM_TGT = NUM_ID + NUM_IMM;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    DATA_LO = 2'd1,
    DATA_HI = 2'd2
  } state_t;

  state_t                         state;
  logic [7:0]                     target;
  logic [15:0]                    count;
  logic [IM_MEM_ADDR_WIDTH-1:0]   addr;
  logic [31:0]                    immLo;

  logic                           accept;
  logic                           targetIsDec;
  logic                           targetIsValid;
  logic                           lastInstr;
  logic [NUM_TGT-1:0]             targetOneHot;
  logic [7:0]                     hdrTarget;
  logic [IM_MEM_ADDR_WIDTH-1:0]   hdrAddr;
  logic [15:0]                    hdrCount;
  logic [I_IMM_WIDTH-1:0]         immWord;

  // The stream is refused while stalled and during the reset cycle.
  assign oLoad_Ready = ~iHold & ~iReset;
  assign accept      = iLoad_Valid & oLoad_Ready;

  // Header field extraction; address bits above the memory width are dropped.
  assign hdrTarget = iLoad_Data[7:0];
  assign hdrAddr   = iLoad_Data[8 +: IM_MEM_ADDR_WIDTH];
  assign hdrCount  = iLoad_Data[31:16];

  assign targetIsDec   = (target < 8'(NUM_ID));
  assign targetIsValid = (target < 8'(NUM_TGT));
  assign lastInstr     = (count == 16'd1);

  // Upper immediate bits come from the second word, lower 32 from the latched first word.
  assign immWord = {iLoad_Data[I_IMM_WIDTH-33:0], immLo};

  // Busy covers both an open command and a write still visible on the output port.
  assign oBusy = (state != HEADER) | (|oIM_WriteEnable);

  // Decode the latched target into a write strobe; invalid targets decode to all-zero.
  always_comb begin
    targetOneHot = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      targetOneHot[i] = (target == 8'(i));
    end
  end

  // Command parser and registered write port.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state             <= HEADER;
      target            <= '0;
      count             <= '0;
      addr              <= '0;
      immLo             <= '0;
      oIM_WriteEnable   <= '0;
      oIM_WriteAddress  <= '0;
      oIM_WriteData     <= '0;
      oIM_WriteData_IMM <= '0;
      oDone             <= 1'b0;
      oError            <= 1'b0;
    end else begin
      oIM_WriteEnable <= '0;
      oDone           <= 1'b0;
      if (accept) begin
        case (state)
          HEADER: begin
            target <= hdrTarget;
            addr   <= hdrAddr;
            count  <= hdrCount;
            if (hdrTarget >= 8'(NUM_TGT)) begin
              oError <= 1'b1;
            end
            if (hdrCount == 16'd0) begin
              oDone <= 1'b1;
            end else begin
              state <= DATA_LO;
            end
          end
          DATA_LO: begin
            if (targetIsDec) begin
              oIM_WriteEnable  <= targetOneHot;
              oIM_WriteAddress <= addr;
              oIM_WriteData    <= iLoad_Data[I_WIDTH-1:0];
              addr             <= addr + 1'b1;
              count            <= count - 16'd1;
              if (lastInstr) begin
                oDone <= 1'b1;
                state <= HEADER;
              end
            end else begin
              immLo <= iLoad_Data[31:0];
              state <= DATA_HI;
            end
          end
          DATA_HI: begin
            // Invalid targets still consume words and advance, but never strobe or change data.
            oIM_WriteEnable  <= targetOneHot;
            oIM_WriteAddress <= addr;
            if (targetIsValid) begin
              oIM_WriteData_IMM <= immWord;
            end
            addr  <= addr + 1'b1;
            count <= count - 16'd1;
            if (lastInstr) begin
              oDone <= 1'b1;
              state <= HEADER;
            end else begin
              state <= DATA_LO;
            end
          end
          default: begin
            state <= HEADER;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cgra_im_loader.sv
// tb/tb_cgra_im_loader.sv - directed self-checking bench for cgra_im_loader
module tb_cgra_im_loader;

  logic        iClk;
  logic        iReset;
  logic        iHold;
  logic [31:0] iLoad_Data;
  logic        iLoad_Valid;
  logic        oLoad_Ready;
  logic [13:0] oIM_WriteEnable;
  logic [7:0]  oIM_WriteAddress;
  logic [11:0] oIM_WriteData;
  logic [32:0] oIM_WriteData_IMM;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lastAcc  = 0;
  int accHdr   = 0;

  logic [13:0] wrWe[$];
  logic [7:0]  wrAddr[$];
  logic [11:0] wrData[$];
  logic [32:0] wrImm[$];
  logic        wrDone[$];
  int          wrCyc[$];
  int          doneCyc[$];

  cgra_im_loader dut (
    .iClk              (iClk),
    .iReset            (iReset),
    .iHold             (iHold),
    .iLoad_Data        (iLoad_Data),
    .iLoad_Valid       (iLoad_Valid),
    .oLoad_Ready       (oLoad_Ready),
    .oIM_WriteEnable   (oIM_WriteEnable),
    .oIM_WriteAddress  (oIM_WriteAddress),
    .oIM_WriteData     (oIM_WriteData),
    .oIM_WriteData_IMM (oIM_WriteData_IMM),
    .oBusy             (oBusy),
    .oDone             (oDone),
    .oError            (oError)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Capture every write strobe and done pulse away from the active edge.
  always @(negedge iClk) begin
    if (|oIM_WriteEnable) begin
      wrWe.push_back(oIM_WriteEnable);
      wrAddr.push_back(oIM_WriteAddress);
      wrData.push_back(oIM_WriteData);
      wrImm.push_back(oIM_WriteData_IMM);
      wrDone.push_back(oDone);
      wrCyc.push_back(cyc);
    end
    if (oDone) doneCyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    wrWe.delete(); wrAddr.delete(); wrData.delete(); wrImm.delete();
    wrDone.delete(); wrCyc.delete(); doneCyc.delete();
  endtask

  // Entered just after a negedge; returns just after the negedge following acceptance.
  task automatic sendWord(input logic [31:0] w, input int gap, input int hold);
    repeat (gap) @(negedge iClk);
    iLoad_Data  = w;
    iLoad_Valid = 1'b1;
    if (hold > 0) begin
      iHold = 1'b1;
      repeat (hold) begin
        #1;
        chk("ready_low_in_hold", 64'(oLoad_Ready), 64'd0);
        @(negedge iClk);
      end
      iHold = 1'b0;
    end
    @(negedge iClk);
    iLoad_Valid = 1'b0;
    lastAcc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    iReset      = 1'b1;
    iHold       = 1'b0;
    iLoad_Data  = '0;
    iLoad_Valid = 1'b0;
    repeat (3) @(negedge iClk);

    // Reset state
    chk("rst_ready", 64'(oLoad_Ready), 64'd0);
    chk("rst_we", 64'(oIM_WriteEnable), 64'd0);
    chk("rst_addr", 64'(oIM_WriteAddress), 64'd0);
    chk("rst_data", 64'(oIM_WriteData), 64'd0);
    chk("rst_imm", 64'(oIM_WriteData_IMM), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_err", 64'(oError), 64'd0);
    iReset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(oLoad_Ready), 64'd1);
    idle(1);
    clearLog();

    // Decoder load to target 4
    sendWord(32'h0003_1004, 0, 0);
    chk("dec_busy", 64'(oBusy), 64'd1);
    sendWord(32'h0000_0ABC, 0, 0);
    accHdr = lastAcc;
    sendWord(32'h0000_0123, 0, 0);
    sendWord(32'h0000_0FFF, 0, 0);
    idle(3);
    chk("dec_count", 64'(wrWe.size()), 64'd3);
    chk("dec_we0", 64'(wrWe[0]), 64'h10);
    chk("dec_we1", 64'(wrWe[1]), 64'h10);
    chk("dec_we2", 64'(wrWe[2]), 64'h10);
    chk("dec_addr0", 64'(wrAddr[0]), 64'h10);
    chk("dec_addr1", 64'(wrAddr[1]), 64'h11);
    chk("dec_addr2", 64'(wrAddr[2]), 64'h12);
    chk("dec_data0", 64'(wrData[0]), 64'hABC);
    chk("dec_data1", 64'(wrData[1]), 64'h123);
    chk("dec_data2", 64'(wrData[2]), 64'hFFF);
    chk("dec_first_cyc", 64'(wrCyc[0]), 64'(accHdr));
    chk("dec_consec1", 64'(wrCyc[1]), 64'(wrCyc[0] + 1));
    chk("dec_consec2", 64'(wrCyc[2]), 64'(wrCyc[1] + 1));
    chk("dec_done01", 64'({wrDone[0], wrDone[1]}), 64'd0);
    chk("dec_done2", 64'(wrDone[2]), 64'd1);
    chk("dec_done_count", 64'(doneCyc.size()), 64'd1);
    chk("dec_imm_hold", 64'(oIM_WriteData_IMM), 64'd0);
    chk("dec_err", 64'(oError), 64'd0);
    chk("dec_idle_busy", 64'(oBusy), 64'd0);
    clearLog();

    // Immediate load to target 11
    sendWord(32'h0001_050B, 0, 0);
    sendWord(32'hDEAD_BEEF, 0, 0);
    idle(2);
    chk("imm_no_early_write", 64'(wrWe.size()), 64'd0);
    chk("imm_busy_mid", 64'(oBusy), 64'd1);
    sendWord(32'h0000_0001, 0, 0);
    idle(3);
    chk("imm_count", 64'(wrWe.size()), 64'd1);
    chk("imm_we", 64'(wrWe[0]), 64'h800);
    chk("imm_addr", 64'(wrAddr[0]), 64'h05);
    chk("imm_data", 64'(wrImm[0]), 64'h1_DEAD_BEEF);
    chk("imm_done", 64'(wrDone[0]), 64'd1);
    chk("imm_dec_hold", 64'(oIM_WriteData), 64'hFFF);
    clearLog();

    // Address wrap, then a zero-count header
    sendWord(32'h0002_FF00, 0, 0);
    sendWord(32'h0000_0001, 0, 0);
    sendWord(32'h0000_0002, 0, 0);
    idle(2);
    chk("wrap_count", 64'(wrWe.size()), 64'd2);
    chk("wrap_addr0", 64'(wrAddr[0]), 64'hFF);
    chk("wrap_addr1", 64'(wrAddr[1]), 64'h00);
    chk("wrap_we", 64'(wrWe[1]), 64'h1);
    chk("wrap_data1", 64'(wrData[1]), 64'h2);
    chk("wrap_err", 64'(oError), 64'd0);
    clearLog();
    sendWord(32'h0000_0002, 0, 0);
    accHdr = lastAcc;
    idle(3);
    chk("n0_no_write", 64'(wrWe.size()), 64'd0);
    chk("n0_done_count", 64'(doneCyc.size()), 64'd1);
    chk("n0_done_cyc", 64'(doneCyc[0]), 64'(accHdr));
    clearLog();

    // Invalid target 0x20
    sendWord(32'h0002_0020, 0, 0);
    chk("inv_err_set", 64'(oError), 64'd1);
    for (int i = 0; i < 4; i++) sendWord(32'h5555_0000 + i, 0, 0);
    accHdr = lastAcc;
    idle(2);
    chk("inv_no_write", 64'(wrWe.size()), 64'd0);
    chk("inv_done_count", 64'(doneCyc.size()), 64'd1);
    chk("inv_done_cyc", 64'(doneCyc[0]), 64'(accHdr));
    chk("inv_idle_busy", 64'(oBusy), 64'd0);
    clearLog();
    sendWord(32'h0001_3000, 0, 0);
    sendWord(32'h0000_0055, 0, 0);
    idle(2);
    chk("inv_next_count", 64'(wrWe.size()), 64'd1);
    chk("inv_next_we", 64'(wrWe[0]), 64'h1);
    chk("inv_next_addr", 64'(wrAddr[0]), 64'h30);
    chk("inv_next_data", 64'(wrData[0]), 64'h055);
    chk("inv_err_sticky", 64'(oError), 64'd1);
    clearLog();

    // Five-instruction immediate load to target 12: gap-free, then with stalls
    for (int run = 0; run < 2; run++) begin
      sendWord(32'h0005_400C, (run == 1) ? 2 : 0, (run == 1) ? 1 : 0);
      for (int i = 0; i < 5; i++) begin
        sendWord(32'hA5A5_0000 | 32'(i), (run == 1) ? int'($urandom_range(0, 2)) : 0,
                 (run == 1) ? int'($urandom_range(0, 2)) : 0);
        sendWord(32'(i % 2), (run == 1) ? int'($urandom_range(0, 2)) : 0,
                 (run == 1) ? int'($urandom_range(0, 2)) : 0);
      end
      idle(2);
      chk($sformatf("bp%0d_count", run), 64'(wrWe.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("bp%0d_we%0d", run, i), 64'(wrWe[i]), 64'h1000);
        chk($sformatf("bp%0d_addr%0d", run, i), 64'(wrAddr[i]), 64'(8'h40 + i));
        chk($sformatf("bp%0d_imm%0d", run, i), 64'(wrImm[i]),
            {31'd0, 1'(i % 2), 32'hA5A5_0000 | 32'(i)});
      end
      chk($sformatf("bp%0d_done", run), 64'(doneCyc.size()), 64'd1);
      clearLog();
    end

    // Reset in the middle of an immediate command
    sendWord(32'h0001_200D, 0, 0);
    sendWord(32'hCAFE_F00D, 0, 0);
    iReset = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(oLoad_Ready), 64'd0);
    @(negedge iClk);
    iReset = 1'b0;
    chk("mid_rst_err", 64'(oError), 64'd0);
    chk("mid_rst_busy", 64'(oBusy), 64'd0);
    chk("mid_rst_imm", 64'(oIM_WriteData_IMM), 64'd0);
    sendWord(32'h0001_7702, 0, 0);
    chk("mid_rst_hdr_nowrite", 64'(wrWe.size()), 64'd0);
    sendWord(32'h0000_0321, 0, 0);
    idle(2);
    chk("mid_rst_count", 64'(wrWe.size()), 64'd1);
    chk("mid_rst_we", 64'(wrWe[0]), 64'h4);
    chk("mid_rst_addr", 64'(wrAddr[0]), 64'h77);
    chk("mid_rst_data", 64'(wrData[0]), 64'h321);
    chk("mid_rst_imm_hold", 64'(oIM_WriteData_IMM), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
